// File: rtl/example_02_driver_pkg.sv
// Shared types and constants for the example_02 detector and its sequence driver.
// Pure declarations: no logic, no latency, no flow control.
package example_02_driver_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4} example_states;

    typedef enum logic [3:0] {
        IDLE,
        STEP_A,
        GAP_A,
        STEP_D1,
        GAP_D1,
        STEP_ABC,
        GAP_ABC,
        STEP_DF,
        FINAL
    } drv_states;

    localparam logic [3:0] D_STEP1 = 4'b0001;
    localparam logic [3:0] D_STEP4 = 4'b1111;

    localparam logic [2:0] QE_STEP_A   = 3'b000;
    localparam logic [2:0] QE_GAP_A    = 3'b010;
    localparam logic [2:0] QE_STEP_D1  = 3'b010;
    localparam logic [2:0] QE_GAP_D1   = 3'b100;
    localparam logic [2:0] QE_STEP_ABC = 3'b101;
    localparam logic [2:0] QE_GAP_ABC  = 3'b111;
    localparam logic [2:0] QE_STEP_DF  = 3'b000;
    localparam logic [2:0] QE_FINAL    = 3'b001;

    // Everything a state decodes to: detector stimulus plus the Q it must produce.
    typedef struct packed {
        logic       a;
        logic       b;
        logic       c;
        logic [3:0] d;
        logic [2:0] q_exp;
        logic       chk;
    } drv_out_t;

endpackage

// File: rtl/example_02_driver_if.sv
// Control and detector-facing signals of the sequence driver.
// master = controller/detector side, slave = the driver itself.
interface example_02_driver_if #(
    parameter int GAP_W = 4
);
    logic             start;
    logic [GAP_W-1:0] gap;
    logic [2:0]       q;
    logic             a;
    logic             b;
    logic             c;
    logic [3:0]       d;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, gap, q,
        input  a, b, c, d, busy, done, err
    );

    modport slave (
        input  start, gap, q,
        output a, b, c, d, busy, done, err
    );
endinterface

// File: rtl/example_02_driver_gap_timer.sv
// Loadable down-counter timing the idle gap between sequence steps; saturates at 0.
// 1-cycle load latency; no backpressure, en simply stalls or advances the count.
module example_02_driver_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] value,
    input  logic             en,
    output logic             last,
    output logic             zero
);
    localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

    logic [GAP_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign last = (cnt == ONE);
    assign zero = (value == '0);

endmodule

// File: rtl/example_02_driver.sv
// Drives the example_02 unlock sequence with a programmable gap and checks Q every cycle.
// Run starts the cycle after start; busy for 5 + 3*gap cycles; start ignored while busy.
module example_02_driver
    import example_02_driver_pkg::*;
#(
    parameter int GAP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    example_02_driver_if.slave  bus
);
    drv_states        state;
    drv_states        nxt;
    logic [GAP_W-1:0] gap_lat;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_last;
    logic             gap_zero;
    logic             err_q;
    logic             done_q;
    drv_out_t         dec;

    example_02_driver_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (gap_lat),
        .en    (tmr_en),
        .last  (tmr_last),
        .zero  (gap_zero)
    );

    // The timer is loaded on the way out of a step so the first gap cycle already sees the full count.
    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            IDLE:     if (bus.start) nxt = STEP_A;
            STEP_A: begin
                nxt      = gap_zero ? STEP_D1 : GAP_A;
                tmr_load = !gap_zero;
            end
            GAP_A: begin
                tmr_en = 1'b1;
                if (tmr_last) nxt = STEP_D1;
            end
            STEP_D1: begin
                nxt      = gap_zero ? STEP_ABC : GAP_D1;
                tmr_load = !gap_zero;
            end
            GAP_D1: begin
                tmr_en = 1'b1;
                if (tmr_last) nxt = STEP_ABC;
            end
            STEP_ABC: begin
                nxt      = gap_zero ? STEP_DF : GAP_ABC;
                tmr_load = !gap_zero;
            end
            GAP_ABC: begin
                tmr_en = 1'b1;
                if (tmr_last) nxt = STEP_DF;
            end
            STEP_DF:  nxt = FINAL;
            FINAL:    nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_comb begin
        dec = '0;
        case (state)
            STEP_A: begin
                dec.a     = 1'b1;
                dec.q_exp = QE_STEP_A;
                dec.chk   = 1'b1;
            end
            GAP_A: begin
                dec.q_exp = QE_GAP_A;
                dec.chk   = 1'b1;
            end
            STEP_D1: begin
                dec.d     = D_STEP1;
                dec.q_exp = QE_STEP_D1;
                dec.chk   = 1'b1;
            end
            GAP_D1: begin
                dec.q_exp = QE_GAP_D1;
                dec.chk   = 1'b1;
            end
            STEP_ABC: begin
                dec.a     = 1'b1;
                dec.b     = 1'b1;
                dec.c     = 1'b1;
                dec.q_exp = QE_STEP_ABC;
                dec.chk   = 1'b1;
            end
            GAP_ABC: begin
                dec.q_exp = QE_GAP_ABC;
                dec.chk   = 1'b1;
            end
            STEP_DF: begin
                dec.d     = D_STEP4;
                dec.q_exp = QE_STEP_DF;
                dec.chk   = 1'b1;
            end
            FINAL: begin
                dec.q_exp = QE_FINAL;
                dec.chk   = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_lat <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= (state == FINAL);
            if ((state == IDLE) && bus.start) begin
                gap_lat <= bus.gap;
                err_q   <= 1'b0;
            end else if (dec.chk && (bus.q != dec.q_exp)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.a    = dec.a;
    assign bus.b    = dec.b;
    assign bus.c    = dec.c;
    assign bus.d    = dec.d;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_example_02_driver.sv
// Bench for example_02_driver: behavioural example_02 detector, per-run expected-sequence
// queues, directed corner runs and randomized runs with fault/restart/chaining.
module tb_example_02_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    example_02_driver_if #(.GAP_W(4)) bus ();

    example_02_driver #(.GAP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Detector model: unlock position 0..4 and its Q as a function of position and inputs.
    int         det_st;
    logic [2:0] det_q;
    logic       q_force;

    always_comb begin
        det_q = 3'b000;
        case (det_st)
            1:       det_q = 3'b010;
            2:       det_q = (bus.a && bus.b && bus.c) ? 3'b101 : 3'b100;
            3:       det_q = (bus.d > 4'd1) ? 3'b000 : 3'b111;
            4:       det_q = 3'b001;
            default: det_q = 3'b000;
        endcase
    end

    assign bus.q = q_force ? 3'b000 : det_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_st <= 0;
        end else begin
            case (det_st)
                0: if (bus.a) det_st <= 1;
                1: if (bus.d == 4'd1) det_st <= 2;
                2: if (bus.a && bus.b && bus.c) det_st <= 3;
                3: if (bus.d > 4'd1) det_st <= 4;
                default: det_st <= 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One run: starts at the current time, returns at the negedge of the done cycle
    // (or after reset recovery when rst_at >= 0). mid_at/rst_at index the busy cycles.
    task automatic run(input int g, input bit fault, input int mid_at, input int rst_at);
        logic [6:0] ev[$];
        logic [2:0] eq[$];
        int         ph[$];
        logic       err_exp;
        int         n;

        ev.push_back(7'b100_0000); eq.push_back(3'b000); ph.push_back(0);
        for (int k = 0; k < g; k++) begin ev.push_back(7'b0); eq.push_back(3'b010); ph.push_back(1); end
        ev.push_back(7'b000_0001); eq.push_back(3'b010); ph.push_back(2);
        for (int k = 0; k < g; k++) begin ev.push_back(7'b0); eq.push_back(3'b100); ph.push_back(3); end
        ev.push_back(7'b111_0000); eq.push_back(3'b101); ph.push_back(4);
        for (int k = 0; k < g; k++) begin ev.push_back(7'b0); eq.push_back(3'b111); ph.push_back(5); end
        ev.push_back(7'b000_1111); eq.push_back(3'b000); ph.push_back(6);
        ev.push_back(7'b0);        eq.push_back(3'b001); ph.push_back(7);
        n = ev.size();

        bus.gap   = 4'(g);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        err_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.start = (i == mid_at);
            if (i == mid_at) bus.gap = 4'($urandom_range(0, 15));
            q_force = fault && (ph[i] == 3);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_busy", bus.busy, 0);
                check("rst_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
                check("rst_err", bus.err, 0);
                check("rst_done", bus.done, 0);
                check("rst_det", det_st, 0);
                q_force   = 1'b0;
                bus.start = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_busy", bus.busy, 0);
                check("post_rst_done", bus.done, 0);
                check("post_rst_err", bus.err, 0);
                return;
            end
            @(negedge clk);
            check("busy", bus.busy, 1);
            check("done_run", bus.done, 0);
            check("abcd", {bus.a, bus.b, bus.c, bus.d}, ev[i]);
            if (!q_force) check("q", bus.q, eq[i]);
            check("err_run", bus.err, err_exp);
            if (q_force) err_exp = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        q_force   = 1'b0;
        @(negedge clk);
        check("end_busy", bus.busy, 0);
        check("end_done", bus.done, 1);
        check("end_err", bus.err, err_exp);
        check("end_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        check("end_det", det_st, 0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
    endtask

    initial begin
        int g;
        bus.start = 1'b0;
        bus.gap   = '0;
        q_force   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        run(0, 1'b0, -1, -1);
        idle_cycle();
        run(2, 1'b0, -1, -1);
        idle_cycle();
        run(15, 1'b0, -1, -1);
        idle_cycle();
        // Faulted run chained straight into a clean one: err must clear in STEP_A.
        run(3, 1'b1, -1, -1);
        run(1, 1'b0, -1, -1);
        idle_cycle();
        run(4, 1'b0, 5, -1);
        idle_cycle();
        // g=2: cycle 7 is the first GAP_ABC cycle.
        run(2, 1'b0, -1, 7);
        run(3, 1'b0, -1, -1);
        idle_cycle();

        for (int r = 0; r < 12; r++) begin
            g = $urandom_range(0, 15);
            run(g, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 4 + 3 * g)) : -1, -1);
            if ($urandom_range(0, 1) != 0) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/example_02_driver.md
# example_02_driver

Sequence driver for the `example_02` five-state detector. On `start` it drives `A`, `B`, `C` and `D` through the detector's unlock sequence S0→S1→S2→S3→S4→S0, with a programmable idle gap between steps. Every cycle of the run, it compares the detector's `Q` against the expected value and keeps a sticky error flag. It sits beside `example_02` in the ch3 designs as its stimulus and self-check counterpart, sharing the same clock.

## Interface
- `GAP_W`, default 4: width of the gap-length input and of the gap counter.

- `clk`  in  1  rising-edge clock, shared with the detector.
- `rst`  in  1  reset, asynchronous, active-high. At integration the detector gets `rstN = ~rst`.
- `start`  in  1  one-cycle request to run a sequence; sampled only in IDLE.
- `gap`  in  GAP_W  idle cycles inserted after each of steps 1–3; latched when `start` is accepted.
- `q`  in  3  detector output `Q`.
- `a`, `b`, `c`  out  1 each  detector inputs `A`, `B`, `C`.
- `d`  out  4  detector input `D`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse when a run completes.
- `err`  out  1  sticky mismatch flag; cleared on `start` acceptance; valid when `done` is high.

## Operation
- Moore machine. All outputs are decoded from the state register only, never from inputs.
- States and the values they drive, as a,b,c,d → expected q:
  - IDLE: 0,0,0,0 → no check.
  - STEP_A: 1,0,0,0 → 000. Detector is in S0.
  - GAP_A: all 0 → 010. Detector is in S1.
  - STEP_D1: 0,0,0,0001 → 010. Detector is in S1.
  - GAP_D1: all 0 → 100. Detector is in S2.
  - STEP_ABC: 1,1,1,0000 → 101. Detector is in S2.
  - GAP_ABC: all 0 → 111. Detector is in S3, and D>1 is false.
  - STEP_DF: 0,0,0,1111 → 000. Detector is in S3.
  - FINAL: all 0 → 001. Detector is in S4.
- Transitions:
  - IDLE→STEP_A on `start`.
  - Each STEP_x goes to GAP_x if the latched gap ≠ 0. Otherwise it goes straight to the next step.
  - GAP_x stays until the gap counter reaches 1, then moves to the next step.
  - STEP_DF→FINAL→IDLE. There is no gap after STEP_DF.
- Gap counter:
  - Loaded with the latched gap on entry to each GAP_x.
  - Decrements each GAP cycle.
  - Unsigned, GAP_W bits, never wraps. An all-ones gap gives exactly 2^GAP_W−1 cycles.
- Check:
  - In every non-IDLE state, if `q` ≠ expected, `err` ← 1 at the next edge.
  - `err` is never cleared mid-run.
- `start` while `busy` is ignored; it is neither queued nor restarts the run.

## Timing
- Reset values: state = IDLE; `a`=`b`=`c`=0; `d`=0; `busy`=0; `done`=0; `err`=0; gap latch = 0; counter = 0.
- `start` high in cycle t puts STEP_A in cycle t+1.
- `busy` is high for exactly 5 + 3·gap cycles.
- `done` is registered. It pulses in the first IDLE cycle after FINAL, and `err` in that cycle includes the FINAL check.
- `start` in the `done` cycle is accepted (back-to-back run). `err` clears in the next cycle, which is STEP_A.
- `q` is compared in the same cycle it is driven; the detector's `Q` is combinational on its state and on our outputs.
- Reset mid-run:
  - Immediately forces IDLE and all-zero outputs, and clears `err`.
  - No `done` pulse.
  - The detector resets to S0 from the same net, so the pair stays aligned.

## Structure
- Shared package `common`:
  - Add enum `drv_states` (the nine states above).
  - Add constants `D_STEP1 = 4'b0001`, `D_STEP4 = 4'b1111`.
  - Add expected-Q constants `QE_STEP_A`, `QE_GAP_A`, …, `QE_FINAL`.
  - Reuse the existing `example_states`.
- One sub-module, `gap_timer`:
  - Loadable GAP_W-bit down-counter.
  - Ports: `clk`, `rst`, `load`, `value`, `en`.
  - Outputs: `last` (count == 1) and `zero` (value == 0).
- Top level:
  - State register with async reset.
  - `always_comb` next-state block.
  - `always_comb` output and expected-Q decode.
  - Registered `err` and `done`.

## Test plan
- gap=0, real `example_02` attached, pulse `start`:
  - `busy` high 5 cycles.
  - `q` seen = 000,010,101,000,001.
  - `done` 1 cycle later with `err`=0.
  - Detector back in S0.
- gap=2:
  - `busy` high 11 cycles.
  - Gap cycles see `q` = 010,010 / 100,100 / 111,111.
  - `done` with `err`=0.
- gap=15 (GAP_W=4):
  - `busy` high 50 cycles; no counter wrap.
  - `err`=0.
- Fault injection: override `q` to 000 during GAP_D1:
  - `err`=1 at `done`.
  - A second clean run clears it: `err`=0 at the next `done`.
- `start` re-pulsed mid-run:
  - Ignored; `busy` length unchanged.
  - `start` in the `done` cycle starts a new run in the next cycle.
- `rst` asserted during GAP_ABC:
  - Outputs 0 and `busy`=0 in that cycle.
  - No `done`, `err`=0.
  - A fresh run after reset release passes.
